// File: rtl/slot_pkg.sv
// Shared types and widths for the slot machine reel logic.
package slot_pkg;
    localparam int SPEED_W  = 26;
    localparam int SYMBOL_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SPIN = 2'd1,
        SLOW = 2'd2,
        DONE = 2'd3
    } reel_state_t;
endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with a registered rising-edge pulse.
// Input rising before edge n gives pulse high after edge n+2; a held level gives one pulse.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic pulse
);
    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_pulse;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_meta  <= d;
            r_sync  <= r_meta;
            r_prev  <= r_sync;
            r_pulse <= r_sync & ~r_prev;
        end
    end

    assign pulse = r_pulse;
endmodule

// File: rtl/reel_controller.sv
// Single-reel sequencer: spin on start, decelerate over a fixed number of steps on stop, then rest.
// Inputs act three clocks after their rising edge; all outputs are registered.
module reel_controller
    import slot_pkg::*;
#(
    parameter int MAX_SPEED   = 50000000,
    parameter int NUM_SYMBOLS = 10,
    parameter int SPIN_SPEED  = 20,
    parameter int SLOW_STEPS  = 8,
    parameter int MIN_SPEED   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                clk_div,
    output logic [SPEED_W-1:0]  speed,
    output logic [SYMBOL_W-1:0] symbol,
    output logic                spinning,
    output logic                done
);
    // The divider cannot produce more than half the system clock rate.
    localparam int SPIN_LIM = (SPIN_SPEED > MAX_SPEED / 2) ? MAX_SPEED / 2 : SPIN_SPEED;
    localparam logic [SPEED_W-1:0]  SPIN_V   = SPEED_W'(SPIN_LIM);
    localparam logic [SPEED_W-1:0]  MIN_V    = SPEED_W'(MIN_SPEED);
    localparam logic [SYMBOL_W-1:0] LAST_SYM = SYMBOL_W'(NUM_SYMBOLS - 1);
    localparam logic [7:0]          SLOW_V   = 8'(SLOW_STEPS);

    logic w_start_ev;
    logic w_stop_ev;
    logic w_tick;

    sync_edge u_sync_start (.clk(clk), .rst(rst), .d(start),   .pulse(w_start_ev));
    sync_edge u_sync_stop  (.clk(clk), .rst(rst), .d(stop),    .pulse(w_stop_ev));
    sync_edge u_sync_div   (.clk(clk), .rst(rst), .d(clk_div), .pulse(w_tick));

    reel_state_t         r_state;
    reel_state_t         w_state_nxt;
    logic [SPEED_W-1:0]  r_speed;
    logic [SPEED_W-1:0]  w_speed_nxt;
    logic [SYMBOL_W-1:0] r_symbol;
    logic [SYMBOL_W-1:0] w_symbol_nxt;
    logic [7:0]          r_slow_cnt;
    logic [7:0]          w_slow_cnt_nxt;
    logic                r_spinning;
    logic                w_spinning_nxt;
    logic                r_done;
    logic                w_done_nxt;

    logic [SYMBOL_W-1:0] w_sym_inc;
    logic [SPEED_W-1:0]  w_speed_half;
    logic [SPEED_W-1:0]  w_speed_slow;

    assign w_sym_inc    = (r_symbol == LAST_SYM) ? '0 : r_symbol + SYMBOL_W'(1);
    assign w_speed_half = r_speed >> 1;
    assign w_speed_slow = (w_speed_half < MIN_V) ? MIN_V : w_speed_half;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_speed    <= '0;
            r_symbol   <= '0;
            r_slow_cnt <= '0;
            r_spinning <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_speed    <= w_speed_nxt;
            r_symbol   <= w_symbol_nxt;
            r_slow_cnt <= w_slow_cnt_nxt;
            r_spinning <= w_spinning_nxt;
            r_done     <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_start_ev) w_state_nxt = SPIN;
            SPIN: if (w_stop_ev)  w_state_nxt = SLOW;
            SLOW: if (w_tick && r_slow_cnt == 8'd1) w_state_nxt = DONE;
            DONE: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // A tick coincident with stop in SPIN advances the symbol but is not a deceleration step.
    always_comb begin
        w_speed_nxt    = r_speed;
        w_symbol_nxt   = r_symbol;
        w_slow_cnt_nxt = r_slow_cnt;
        case (r_state)
            IDLE: w_speed_nxt = w_start_ev ? SPIN_V : '0;
            SPIN: begin
                if (w_tick)    w_symbol_nxt   = w_sym_inc;
                if (w_stop_ev) w_slow_cnt_nxt = SLOW_V;
            end
            SLOW: begin
                if (w_tick) begin
                    w_symbol_nxt   = w_sym_inc;
                    w_speed_nxt    = w_speed_slow;
                    w_slow_cnt_nxt = r_slow_cnt - 8'd1;
                end
            end
            DONE: w_speed_nxt = '0;
            default: w_speed_nxt = '0;
        endcase
        w_spinning_nxt = (w_state_nxt == SPIN) || (w_state_nxt == SLOW);
        w_done_nxt     = (r_state == DONE);
    end

    assign speed    = r_speed;
    assign symbol   = r_symbol;
    assign spinning = r_spinning;
    assign done     = r_done;
endmodule

// File: tb/tb_reel_controller.sv
// Directed and random stimulus for reel_controller, checked against a behavioural reel model.
module tb_reel_controller;
    localparam int NS   = 10;
    localparam int SPD  = 20;
    localparam int STPS = 3;
    localparam int MINS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        clk_div = 1'b0;
    logic [25:0] speed;
    logic [3:0]  symbol;
    logic        spinning;
    logic        done;

    reel_controller #(
        .MAX_SPEED(50000000), .NUM_SYMBOLS(NS), .SPIN_SPEED(SPD),
        .SLOW_STEPS(STPS), .MIN_SPEED(MINS)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clk_div(clk_div),
        .speed(speed), .symbol(symbol), .spinning(spinning), .done(done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model: reel mode, remaining deceleration steps, and per-input sample history.
    string       m_mode = "IDLE";
    int          m_left = 0;
    int          m_speed = 0;
    int          m_sym = 0;
    bit          m_spin = 0;
    bit          m_done = 0;
    logic [4:0]  h_start = '0, h_stop = '0, h_div = '0;
    bit          saw_wrap = 0;
    int          prev_sym = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // An input rise sampled at edge k is acted on at edge k+3.
    task automatic model_edge(input logic s, input logic p, input logic d, input logic r);
        bit es, ep, et;
        h_start = {h_start[3:0], s};
        h_stop  = {h_stop[3:0], p};
        h_div   = {h_div[3:0], d};
        if (r) begin
            h_start = '0; h_stop = '0; h_div = '0;
            m_mode = "IDLE"; m_left = 0; m_speed = 0; m_sym = 0; m_spin = 0; m_done = 0;
            return;
        end
        es = h_start[3] & ~h_start[4];
        ep = h_stop[3] & ~h_stop[4];
        et = h_div[3] & ~h_div[4];
        m_done = (m_mode == "DONE");
        if (m_mode == "IDLE") begin
            m_speed = es ? SPD : 0;
            if (es) m_mode = "SPIN";
        end else if (m_mode == "SPIN") begin
            if (et) m_sym = (m_sym + 1) % NS;
            if (ep) begin m_mode = "SLOW"; m_left = STPS; end
        end else if (m_mode == "SLOW") begin
            if (et) begin
                m_sym = (m_sym + 1) % NS;
                m_speed = (m_speed / 2 < MINS) ? MINS : m_speed / 2;
                m_left = m_left - 1;
                if (m_left == 0) m_mode = "DONE";
            end
        end else begin
            m_speed = 0;
            m_mode = "IDLE";
        end
        m_spin = (m_mode == "SPIN") || (m_mode == "SLOW");
    endtask

    task automatic cyc(input logic s, input logic p, input logic d, input logic r);
        start = s; stop = p; clk_div = d; rst = r;
        @(posedge clk);
        model_edge(s, p, d, r);
        #1;
        chk("model_speed", int'(speed), m_speed);
        chk("model_symbol", int'(symbol), m_sym);
        chk("model_spinning", int'(spinning), int'(m_spin));
        chk("model_done", int'(done), int'(m_done));
        if (prev_sym == NS - 1 && int'(symbol) == 0) saw_wrap = 1;
        prev_sym = int'(symbol);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
    endtask

    task automatic tick();
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
    endtask

    task automatic slow_tick(input int exp_speed);
        cyc(0, 0, 1, 0);
        idle_cycles(3);
        chk("slow_speed", int'(speed), exp_speed);
    endtask

    initial begin
        // Reset and IDLE ignores divider edges
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        chk("rst_speed", int'(speed), 0);
        chk("rst_symbol", int'(symbol), 0);
        chk("rst_spinning", int'(spinning), 0);
        chk("rst_done", int'(done), 0);
        for (int i = 0; i < 10; i++) tick();
        idle_cycles(4);
        chk("idle_symbol", int'(symbol), 0);

        // Held start: one event, visible three cycles after the rise
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("start_lat_spinning", int'(spinning), 0);
        cyc(1, 0, 0, 0);
        chk("start_spinning", int'(spinning), 1);
        chk("start_speed", int'(speed), 20);
        for (int i = 0; i < 96; i++) cyc(1, 0, 0, 0);
        idle_cycles(4);
        saw_wrap = 0;
        for (int i = 0; i < 12; i++) tick();
        idle_cycles(3);
        chk("spin_symbol", int'(symbol), 2);
        chk("spin_wrap", int'(saw_wrap), 1);

        // Second start in SPIN has no effect
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        idle_cycles(5);
        chk("restart_spinning", int'(spinning), 1);
        chk("restart_speed", int'(speed), 20);
        chk("restart_symbol", int'(symbol), 2);

        // Stop, three deceleration steps, then done
        cyc(0, 1, 0, 0);
        idle_cycles(5);
        chk("slow_entry_speed", int'(speed), 20);
        slow_tick(10);
        slow_tick(5);
        slow_tick(4);
        chk("done_state_pulse", int'(done), 0);
        cyc(0, 0, 0, 0);
        chk("done_pulse", int'(done), 1);
        chk("done_speed", int'(speed), 0);
        chk("done_spinning", int'(spinning), 0);
        chk("done_symbol", int'(symbol), 5);
        cyc(0, 0, 0, 0);
        chk("done_one_cycle", int'(done), 0);

        // Start and stop together in IDLE: start wins
        cyc(1, 1, 0, 0);
        idle_cycles(5);
        chk("both_idle_spinning", int'(spinning), 1);
        chk("both_idle_speed", int'(speed), 20);

        // Stop alone in IDLE is ignored
        cyc(0, 0, 0, 1);
        idle_cycles(2);
        cyc(0, 1, 0, 0);
        idle_cycles(5);
        chk("stop_idle_spinning", int'(spinning), 0);
        chk("stop_idle_speed", int'(speed), 0);

        // Tick coincident with stop in SPIN: advance and enter SLOW with a full count
        cyc(1, 0, 0, 0);
        idle_cycles(5);
        cyc(0, 1, 1, 0);
        idle_cycles(5);
        chk("coinc_symbol", int'(symbol), 1);
        chk("coinc_speed", int'(speed), 20);
        slow_tick(10);
        slow_tick(5);
        chk("coinc_still_spinning", int'(spinning), 1);
        slow_tick(4);
        cyc(0, 0, 0, 0);
        chk("coinc_done", int'(done), 1);
        chk("coinc_symbol_end", int'(symbol), 4);

        // Reset in the middle of deceleration
        cyc(1, 0, 0, 0);
        idle_cycles(5);
        cyc(0, 1, 0, 0);
        idle_cycles(5);
        slow_tick(10);
        cyc(0, 0, 0, 1);
        chk("midrst_speed", int'(speed), 0);
        chk("midrst_symbol", int'(symbol), 0);
        chk("midrst_spinning", int'(spinning), 0);
        chk("midrst_done", int'(done), 0);
        for (int i = 0; i < 5; i++) tick();
        idle_cycles(4);
        chk("midrst_ticks_ignored", int'(symbol), 0);

        // Random buttons, divider and occasional reset
        begin
            logic s, p, d, r;
            s = 0; p = 0; d = 0;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(0, 40) == 0) s = ~s;
                if ($urandom_range(0, 60) == 0) p = ~p;
                if ($urandom_range(0, 2) == 0)  d = ~d;
                r = ($urandom_range(0, 700) == 0);
                cyc(s, p, d, r);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
